// File: rtl/pat_serializer.sv
// pat_serializer: parallel-to-serial feeder for the PAT detector, LSB first, with a programmable idle gap.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
`default_nettype none

module pat_serializer #(
    parameter int WIDTH = 12,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             data,
    output logic             data_valid,
    output logic             first,
    output logic             done,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam bit               HAS_GAP  = (GAP != 0);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2, S_GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd3} state_t;
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(WIDTH - 2);
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       gcnt, gcnt_n;
    logic             data_n, valid_n, first_n, done_n;
`ifdef SER_PARITY_EN
    logic             parity, parity_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            first      <= 1'b0;
            done       <= 1'b0;
`ifdef SER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            gcnt       <= gcnt_n;
            data       <= data_n;
            data_valid <= valid_n;
            first      <= first_n;
            done       <= done_n;
`ifdef SER_PARITY_EN
            parity     <= parity_n;
`endif
        end
    end

    // Output registers hold the bit currently on the wire; cnt is that bit's index.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        data_n  = 1'b0;
        valid_n = 1'b0;
        first_n = 1'b0;
        done_n  = 1'b0;
`ifdef SER_PARITY_EN
        parity_n = parity;
`endif
        case (state)
            S_IDLE: begin
                if (load_valid) begin
                    state_n = S_SHIFT;
                    shreg_n = load_data >> 1;
                    cnt_n   = '0;
                    data_n  = load_data[0];
                    valid_n = 1'b1;
                    first_n = 1'b1;
`ifdef SER_PARITY_EN
                    parity_n = ^load_data;
`endif
                end
            end
            S_SHIFT: begin
                if (cnt == LAST_BIT) begin
`ifdef SER_PARITY_EN
                    state_n = S_PARITY;
                    data_n  = parity;
                    valid_n = 1'b1;
                    done_n  = 1'b1;
`else
                    state_n = HAS_GAP ? S_GAP : S_IDLE;
                    gcnt_n  = '0;
`endif
                end else begin
                    cnt_n   = cnt + 1'b1;
                    data_n  = shreg[0];
                    shreg_n = shreg >> 1;
                    valid_n = 1'b1;
`ifndef SER_PARITY_EN
                    done_n  = (cnt == PENULT);
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                state_n = HAS_GAP ? S_GAP : S_IDLE;
                gcnt_n  = '0;
            end
`endif
            S_GAP: begin
                if (gcnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    gcnt_n  = '0;
                end else begin
                    gcnt_n  = gcnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign load_ready = (state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pat_serializer.sv
// Bench for pat_serializer: two instances (GAP=1 and GAP=0) checked against a frame-level model.
`default_nettype none

module tb_pat_serializer;

    localparam int WIDTH = 12;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = WIDTH + PAR;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       lv;
    logic [WIDTH-1:0] ld [2];
    logic [1:0]       lr, dat, dv, fst, dn, bsy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pat_serializer #(.WIDTH(WIDTH), .GAP(1)) u_gap1 (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]),
        .load_ready(lr[0]), .data(dat[0]), .data_valid(dv[0]), .first(fst[0]),
        .done(dn[0]), .busy(bsy[0])
    );

    pat_serializer #(.WIDTH(WIDTH), .GAP(0)) u_gap0 (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]),
        .load_ready(lr[1]), .data(dat[1]), .data_valid(dv[1]), .first(fst[1]),
        .done(dn[1]), .busy(bsy[1])
    );

    function automatic int gap_of(int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Frame bit i: word bits LSB first, then the even-parity bit if enabled.
    function automatic logic exp_bit(logic [WIDTH-1:0] w, int i);
        if (i < WIDTH) return ((w >> i) % 2) != 0;
        return ($countones(w) % 2) != 0;
    endfunction

    task automatic check(string tag, int d, logic obs, logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s dut=%0d t=%0t observed=%b expected=%b", tag, d, $time, obs, exp);
        end
    endtask

    task automatic check_idle(int d, string tag);
        check({tag, "_data"},  d, dat[d], 1'b0);
        check({tag, "_valid"}, d, dv[d],  1'b0);
        check({tag, "_first"}, d, fst[d], 1'b0);
        check({tag, "_done"},  d, dn[d],  1'b0);
        check({tag, "_busy"},  d, bsy[d], 1'b0);
        check({tag, "_ready"}, d, lr[d],  1'b1);
    endtask

    // Offer w from IDLE, then check the whole frame, the gap and the return to IDLE.
    // With hold set, load_valid stays high carrying nxt during the frame.
    task automatic send(int d, logic [WIDTH-1:0] w, bit hold, logic [WIDTH-1:0] nxt);
        lv[d] = 1'b1;
        ld[d] = w;
        check("ready_before", d, lr[d], 1'b1);
        @(negedge clk);
        if (hold) ld[d] = nxt;
        else      lv[d] = 1'b0;
        for (int i = 0; i < FL; i++) begin
            check("bit_data",  d, dat[d], exp_bit(w, i));
            check("bit_valid", d, dv[d],  1'b1);
            check("bit_first", d, fst[d], i == 0);
            check("bit_done",  d, dn[d],  i == FL - 1);
            check("bit_busy",  d, bsy[d], 1'b1);
            check("bit_ready", d, lr[d],  1'b0);
            @(negedge clk);
        end
        for (int g = 0; g < gap_of(d); g++) begin
            check("gap_data",  d, dat[d], 1'b0);
            check("gap_valid", d, dv[d],  1'b0);
            check("gap_done",  d, dn[d],  1'b0);
            check("gap_busy",  d, bsy[d], 1'b1);
            check("gap_ready", d, lr[d],  1'b0);
            @(negedge clk);
        end
        check_idle(d, "post");
    endtask

    initial begin
        logic [WIDTH-1:0] w, nxt;
        bit               hold;
        int               idle;

        reset = 1'b1;
        lv    = 2'b00;
        ld[0] = '0;
        ld[1] = '0;
        repeat (2) @(negedge clk);
        check_idle(0, "reset");
        check_idle(1, "reset");
        reset = 1'b0;
        @(negedge clk);

        send(0, 12'b101101011101, 1'b0, '0);
        send(0, 12'h001, 1'b0, '0);

        // Load request held with a different word during a transfer.
        send(0, 12'hFFF, 1'b1, 12'h000);
        send(0, 12'h000, 1'b0, '0);

        // GAP=0 instance with load_valid held: one idle cycle between words.
        send(1, 12'hAAA, 1'b1, 12'h555);
        send(1, 12'h555, 1'b0, '0);

        // Reset while bit 5 of a word is on the wire.
        lv[0] = 1'b1;
        ld[0] = 12'hFFF;
        @(negedge clk);
        lv[0] = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            check("abort_data",  0, dat[0], 1'b1);
            check("abort_valid", 0, dv[0],  1'b1);
            check("abort_done",  0, dn[0],  1'b0);
            if (i < 5) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle(0, "abort");
        @(negedge clk);
        check_idle(0, "abort_after");

        // Reset and load request on the same edge: word dropped.
        reset = 1'b1;
        lv[0] = 1'b1;
        ld[0] = WIDTH'($urandom);
        @(negedge clk);
        reset = 1'b0;
        lv[0] = 1'b0;
        check_idle(0, "rst_load");
        @(negedge clk);
        check_idle(0, "rst_load_after");

        for (int d = 0; d < 2; d++) begin
            w = WIDTH'($urandom);
            for (int n = 0; n < 15; n++) begin
                hold = (n < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
                nxt  = WIDTH'($urandom);
                send(d, w, hold, nxt);
                if (hold) begin
                    w = nxt;
                end else begin
                    idle = $urandom_range(0, 3);
                    repeat (idle) begin
                        @(negedge clk);
                        check_idle(d, "rand_idle");
                    end
                    w = WIDTH'($urandom);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
